// File: rtl/drisc_cpu_if.sv
// drisc_cpu_if: memory-bus strobes and address of the DRISC core.
// master = core side, slave = memory side; io_bus stays a plain inout.
interface drisc_cpu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address_bus;
  logic [1:0]            data_size;
  logic                  write_address;
  logic                  write;
  logic                  read;
  logic [6:0]            opcode_debug;

  modport master (
    output address_bus, data_size,
    output write_address, write, read,
    output opcode_debug
  );

  modport slave (
    input address_bus, data_size,
    input write_address, write, read,
    input opcode_debug
  );
endinterface

// File: rtl/drisc_cpu.sv
// drisc_cpu: three-cycle RV32I core on a latched-address byte bus.
// Ports: clock, reset (async high), io_bus (inout data), bus (master).
module drisc_cpu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  inout  wire   [31:0] io_bus,
  drisc_cpu_if.master  bus
);

  typedef enum logic [2:0] {
    PH_FETCH = 3'b001,
    PH_DATA  = 3'b010,
    PH_EXEC  = 3'b100
  } phase_t;

  phase_t      r_phase;
  logic [31:0] r_pc;
  logic [31:0] r_cur;
  logic [31:0] r_next;
  logic [31:0] r_regs [32];

  logic [6:0]  w_op;
  logic [4:0]  w_rd;
  logic [4:0]  w_ra1;
  logic [4:0]  w_ra2;
  logic [2:0]  w_f3;
  logic [31:0] w_rs1;
  logic [31:0] w_rs2;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_u;

  assign w_op  = r_cur[6:0];
  assign w_rd  = r_cur[11:7];
  assign w_f3  = r_cur[14:12];
  assign w_ra1 = r_cur[19:15];
  assign w_ra2 = r_cur[24:20];

  assign w_rs1 = (w_ra1 == 5'd0) ? 32'd0 : r_regs[w_ra1];
  assign w_rs2 = (w_ra2 == 5'd0) ? 32'd0 : r_regs[w_ra2];

  assign w_imm_i = {{20{r_cur[31]}}, r_cur[31:20]};
  assign w_imm_s = {{20{r_cur[31]}}, r_cur[31:25], r_cur[11:7]};
  assign w_imm_b = {{19{r_cur[31]}}, r_cur[31], r_cur[7],
                    r_cur[30:25], r_cur[11:8], 1'b0};
  assign w_imm_j = {{11{r_cur[31]}}, r_cur[31], r_cur[19:12],
                    r_cur[20], r_cur[30:21], 1'b0};
  assign w_imm_u = {r_cur[31:12], 12'd0};

  logic w_lui, w_auipc, w_jal, w_jalr;
  logic w_br, w_ld, w_st, w_opi, w_opr;

  assign w_lui   = (w_op == 7'b0110111);
  assign w_auipc = (w_op == 7'b0010111);
  assign w_jal   = (w_op == 7'b1101111);
  assign w_jalr  = (w_op == 7'b1100111);
  assign w_br    = (w_op == 7'b1100011);
  assign w_ld    = (w_op == 7'b0000011);
  assign w_st    = (w_op == 7'b0100011);
  assign w_opi   = (w_op == 7'b0010011);
  assign w_opr   = (w_op == 7'b0110011);

  logic w_taken;
  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = (w_rs1 == w_rs2);
      3'b001:  w_taken = (w_rs1 != w_rs2);
      3'b100:  w_taken = ($signed(w_rs1) < $signed(w_rs2));
      3'b101:  w_taken = ($signed(w_rs1) >= $signed(w_rs2));
      3'b110:  w_taken = (w_rs1 < w_rs2);
      3'b111:  w_taken = (w_rs1 >= w_rs2);
      default: w_taken = 1'b0;
    endcase
  end

  // Next PC is fully known from the current instruction, so the
  // prefetch in phase 010 never has to be discarded.
  logic [31:0] w_pc4;
  logic [31:0] w_next_pc;
  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    w_next_pc = w_pc4;
    unique case (1'b1)
      w_jal:            w_next_pc = r_pc + w_imm_j;
      w_jalr:           w_next_pc = (w_rs1 + w_imm_i) & ~32'd1;
      w_br && w_taken:  w_next_pc = r_pc + w_imm_b;
      default:          w_next_pc = w_pc4;
    endcase
  end

  // SRAI/SUB select comes from bit 30; for OP-IMM only shifts honour it.
  logic [31:0] w_opb;
  logic [4:0]  w_sh;
  logic        w_alt;
  logic [31:0] w_alu;
  assign w_opb = w_opr ? w_rs2 : w_imm_i;
  assign w_sh  = w_opb[4:0];
  assign w_alt = r_cur[30] & (w_opr | (w_f3 == 3'b101));

  always_comb begin
    w_alu = 32'd0;
    case (w_f3)
      3'b000:  w_alu = w_alt ? (w_rs1 - w_opb) : (w_rs1 + w_opb);
      3'b001:  w_alu = w_rs1 << w_sh;
      3'b010:  w_alu = {31'd0, $signed(w_rs1) < $signed(w_opb)};
      3'b011:  w_alu = {31'd0, w_rs1 < w_opb};
      3'b100:  w_alu = w_rs1 ^ w_opb;
      3'b101:  w_alu = w_alt ? 32'($signed(w_rs1) >>> w_sh)
                             : (w_rs1 >> w_sh);
      3'b110:  w_alu = w_rs1 | w_opb;
      default: w_alu = w_rs1 & w_opb;
    endcase
  end

  // Memory returns zero-extended data; only LB/LH need sign fill.
  logic [31:0] w_ld_data;
  always_comb begin
    w_ld_data = io_bus;
    case (w_f3)
      3'b000:  w_ld_data = {{24{io_bus[7]}}, io_bus[7:0]};
      3'b001:  w_ld_data = {{16{io_bus[15]}}, io_bus[15:0]};
      3'b100:  w_ld_data = {24'd0, io_bus[7:0]};
      3'b101:  w_ld_data = {16'd0, io_bus[15:0]};
      default: w_ld_data = io_bus;
    endcase
  end

  logic [31:0] w_wb_data;
  logic        w_wb_en;
  assign w_wb_en = w_lui | w_auipc | w_jal | w_jalr
                 | w_ld | w_opi | w_opr;

  always_comb begin
    w_wb_data = 32'd0;
    unique case (1'b1)
      w_lui:           w_wb_data = w_imm_u;
      w_auipc:         w_wb_data = r_pc + w_imm_u;
      w_jal || w_jalr: w_wb_data = w_pc4;
      w_ld:            w_wb_data = w_ld_data;
      w_opi || w_opr:  w_wb_data = w_alu;
      default:         w_wb_data = 32'd0;
    endcase
  end

  logic [31:0] w_ls_addr;
  assign w_ls_addr = w_rs1 + (w_st ? w_imm_s : w_imm_i);

  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic        w_wa;
  logic        w_rd_s;
  logic        w_wr_s;

  // Strobes are forced low while reset is held, whatever the phase.
  always_comb begin
    w_addr = w_next_pc;
    w_size = 2'b10;
    w_wa   = 1'b0;
    w_rd_s = 1'b0;
    w_wr_s = 1'b0;
    if (!reset) begin
      unique case (r_phase)
        PH_FETCH: w_wa = 1'b1;
        PH_DATA: begin
          w_rd_s = 1'b1;
          if (w_ld || w_st) begin
            w_addr = w_ls_addr;
            w_wa   = 1'b1;
          end
        end
        PH_EXEC: begin
          if (w_ld || w_st) w_size = w_f3[1:0];
          w_rd_s = w_ld;
          w_wr_s = w_st;
        end
        default: w_wa = 1'b0;
      endcase
    end
  end

  assign bus.address_bus   = w_addr[ADDR_WIDTH-1:0];
  assign bus.data_size     = w_size;
  assign bus.write_address = w_wa;
  assign bus.read          = w_rd_s;
  assign bus.write         = w_wr_s;
  assign bus.opcode_debug  = w_op;

  assign io_bus = w_wr_s ? w_rs2 : 32'bz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase <= PH_FETCH;
      r_pc    <= 32'hFFFF_FFFC;
      r_cur   <= 32'h0000_0013;
      r_next  <= 32'd0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
      unique case (r_phase)
        PH_FETCH: r_phase <= PH_DATA;
        PH_DATA: begin
          r_phase <= PH_EXEC;
          r_next  <= io_bus;
        end
        PH_EXEC: begin
          r_phase <= PH_FETCH;
          r_pc    <= w_next_pc;
          r_cur   <= r_next;
          if (w_wb_en && (w_rd != 5'd0))
            r_regs[w_rd] <= w_wb_data;
        end
        default: r_phase <= PH_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_drisc_cpu.sv
// tb_drisc_cpu: drisc_cpu on a byte RAM, checked against an ISA model.
// Directed programs plus random instruction mixes.
module tb_drisc_cpu;

  logic clock = 1'b0;
  logic reset = 1'b1;
  wire  [31:0] io_bus;

  drisc_cpu_if #(.ADDR_WIDTH(32)) bus ();

  drisc_cpu #(.ADDR_WIDTH(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (io_bus),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  logic [7:0]  mem [1024];
  logic [31:0] ram_addr = 32'd0;
  logic [31:0] ram_rd;

  always_comb begin
    ram_rd = 32'd0;
    ram_rd[7:0] = mem[ram_addr[9:0]];
    if (bus.data_size != 2'b00)
      ram_rd[15:8] = mem[ram_addr[9:0] + 10'd1];
    if (bus.data_size[1]) begin
      ram_rd[23:16] = mem[ram_addr[9:0] + 10'd2];
      ram_rd[31:24] = mem[ram_addr[9:0] + 10'd3];
    end
  end

  assign io_bus = bus.read ? ram_rd : 32'bz;

  always @(posedge clock) begin
    if (bus.write) begin
      mem[ram_addr[9:0]] <= io_bus[7:0];
      if (bus.data_size != 2'b00)
        mem[ram_addr[9:0] + 10'd1] <= io_bus[15:8];
      if (bus.data_size[1]) begin
        mem[ram_addr[9:0] + 10'd2] <= io_bus[23:16];
        mem[ram_addr[9:0] + 10'd3] <= io_bus[31:24];
      end
    end
    if (bus.write_address) ram_addr <= bus.address_bus;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- ISA reference model ----------------
  logic [31:0] m_x [32];
  logic [7:0]  m_mem [1024];
  logic [31:0] m_pc;

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = m_mem[(a + i) & 1023];
    return w;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f3,
      input logic alt, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] in, a, b, ii, si, bi, ji, res, nxt, ea, v;
    logic [2:0] f3;
    logic [4:0] rd;
    logic wr;
    int nb;
    in = m_word(m_pc);
    rd = in[11:7];
    f3 = in[14:12];
    a  = m_x[in[19:15]];
    b  = m_x[in[24:20]];
    ii = {{20{in[31]}}, in[31:20]};
    si = {{20{in[31]}}, in[31:25], in[11:7]};
    bi = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
    ji = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    nxt = m_pc + 4;
    res = 0;
    wr  = 0;
    case (in[6:0])
      7'h37: begin res = {in[31:12], 12'd0}; wr = 1; end
      7'h17: begin res = m_pc + {in[31:12], 12'd0}; wr = 1; end
      7'h6F: begin res = m_pc + 4; nxt = m_pc + ji; wr = 1; end
      7'h67: begin res = m_pc + 4; nxt = (a + ii) & ~32'd1; wr = 1; end
      7'h63: if (taken(f3, a, b)) nxt = m_pc + bi;
      7'h03: begin
        ea = a + ii;
        v = 0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = m_mem[(ea + i) & 1023];
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        res = v;
        wr = 1;
      end
      7'h23: begin
        ea = a + si;
        for (int i = 0; i < nb; i++) m_mem[(ea + i) & 1023] = b[8*i +: 8];
      end
      7'h13: begin res = alu(f3, f3 == 3'd5 && in[30], a, ii); wr = 1; end
      7'h33: begin res = alu(f3, in[30], a, b); wr = 1; end
      default: ;
    endcase
    if (wr && rd != 0) m_x[rd] = res;
    m_pc = nxt;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] e_i(input logic [31:0] imm,
      input int rs1, input logic [2:0] f3, input int rd,
      input logic [6:0] op);
    return {imm[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] e_r(input logic [6:0] f7, input int rs2,
      input int rs1, input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] e_s(input logic [31:0] imm,
      input int rs2, input int rs1, input logic [2:0] f3);
    return {imm[11:5], 5'(rs2), 5'(rs1), f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] e_b(input logic [31:0] imm,
      input int rs2, input int rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), f3,
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] e_j(input logic [31:0] imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'h6F};
  endfunction

  function automatic logic [31:0] e_u(input logic [31:0] hi, input int rd,
      input logic [6:0] op);
    return {hi[19:0], 5'(rd), op};
  endfunction

  // ---------------- helpers ----------------
  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'h00;
      m_mem[i] = 8'h00;
    end
  endtask

  task automatic put(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[(a + i) & 1023] = w[8*i +: 8];
      m_mem[(a + i) & 1023] = w[8*i +: 8];
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_wa", bus.write_address, 0);
    chk("rst_rd", bus.read, 0);
    chk("rst_wr", bus.write, 0);
    chk("rst_op", bus.opcode_debug, 32'h13);
    for (int i = 0; i < 32; i++) m_x[i] = 0;
    m_pc = 0;
    reset = 1'b0;
    #1;
    chk("boot_addr", bus.address_bus, 0);
    chk("boot_wa", bus.write_address, 1);
    @(posedge clock); #1;
    chk("boot_op2", bus.opcode_debug, 32'h13);
    @(posedge clock); #1;
    chk("boot_op3", bus.opcode_debug, 32'h13);
    @(posedge clock);
  endtask

  task automatic run_steps(input int n);
    logic [31:0] fa, w;
    logic wa;
    for (int k = 0; k < n; k++) begin
      #1;
      fa = bus.address_bus;
      wa = bus.write_address;
      w  = m_word(m_pc);
      chk($sformatf("pc@%0d", k), dut.r_pc, m_pc);
      chk($sformatf("opc@%0d", k), bus.opcode_debug, {25'd0, w[6:0]});
      model_step();
      chk($sformatf("fetch@%0d", k), fa, m_pc);
      chk($sformatf("fetch_wa@%0d", k), wa, 1);
      repeat (3) @(posedge clock);
    end
  endtask

  task automatic final_cmp(input string t);
    #1;
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_x%0d", t, i), dut.r_regs[i], m_x[i]);
    for (int i = 0; i < 1024; i++)
      if (mem[i] !== m_mem[i])
        chk($sformatf("%s_mem%0h", t, i), {24'd0, mem[i]},
            {24'd0, m_mem[i]});
    chk({t, "_pc"}, dut.r_pc, m_pc);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] imm;
    logic [2:0]  f3;
    int rd, r1, r2;
    rd = $urandom_range(0, 31);
    r1 = $urandom_range(0, 31);
    r2 = $urandom_range(0, 31);
    imm = $urandom;
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        if (f3 == 3'd1) imm[11:5] = 7'd0;
        if (f3 == 3'd5) imm[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return e_i(imm, r1, f3, rd, 7'h13);
      end
      3, 4: return e_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1))
                       ? 7'h20 : 7'h00, r2, r1, f3, rd);
      5: return e_u(imm, rd, $urandom_range(0, 1) ? 7'h37 : 7'h17);
      6: return e_s(32'h200 + $urandom_range(0, 32'h1F8), r2, 0,
                    3'($urandom_range(0, 2)));
      7: begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2;
          3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
        return e_i(32'h200 + $urandom_range(0, 32'h1F8), 0, f3, rd, 7'h03);
      end
      8: begin
        if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd4;
        return e_b(32'd8, r2, r1, f3);
      end
      default: return e_i(32'($urandom_range(0, 63)) - 32, rd, 3'd0, rd,
                          7'h13);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // straight-line ALU
    clear_mem();
    put(0, e_i(5, 0, 0, 1, 7'h13));
    put(4, e_i(-7, 1, 0, 2, 7'h13));
    put(8, e_r(7'h20, 2, 1, 0, 3));
    do_reset();
    run_steps(3);
    final_cmp("alu");
    chk("alu_x1", dut.r_regs[1], 5);
    chk("alu_x2", dut.r_regs[2], 32'hFFFF_FFFE);
    chk("alu_x3", dut.r_regs[3], 7);

    // JAL skips 4, JALR returns to 4
    clear_mem();
    put(0, e_j(8, 1));
    put(4, e_i(1, 5, 0, 5, 7'h13));
    put(8, e_i(0, 1, 0, 0, 7'h67));
    do_reset();
    run_steps(1);
    #1;
    chk("jal_x1", dut.r_regs[1], 4);
    chk("jal_pc", dut.r_pc, 8);
    chk("jal_skip", dut.r_regs[5], 0);
    run_steps(2);
    final_cmp("jalr");
    chk("jalr_x5", dut.r_regs[5], 1);

    // branches: {rs1 value, rs2 value, funct3, expected pc}
    begin
      logic [31:0] bt [4][4];
      bt[0] = '{32'd3, 32'd3, 32'd0, 32'd20};
      bt[1] = '{32'd3, 32'd4, 32'd0, 32'd12};
      bt[2] = '{-32'd1, 32'd1, 32'd4, 32'd20};
      bt[3] = '{-32'd1, 32'd1, 32'd6, 32'd12};
      for (int t = 0; t < 4; t++) begin
        clear_mem();
        put(0, e_i(bt[t][0], 0, 0, 1, 7'h13));
        put(4, e_i(bt[t][1], 0, 0, 2, 7'h13));
        put(8, e_b(12, 2, 1, 3'(bt[t][2])));
        do_reset();
        run_steps(3);
        final_cmp($sformatf("br%0d", t));
        chk($sformatf("br%0d_target", t), dut.r_pc, bt[t][3]);
      end
    end

    // stores and loads
    clear_mem();
    put(0,  e_u(32'h80FF8, 1, 7'h37));
    put(4,  e_i(-255, 1, 0, 1, 7'h13));
    put(8,  e_s(32'h100, 1, 0, 3'd0));
    put(12, e_s(32'h100, 1, 0, 3'd1));
    put(16, e_s(32'h100, 1, 0, 3'd2));
    put(20, e_i(32'h100, 0, 3'd0, 2, 7'h03));
    put(24, e_i(32'h102, 0, 3'd4, 3, 7'h03));
    put(28, e_i(32'h102, 0, 3'd1, 4, 7'h03));
    put(32, e_i(32'h100, 0, 3'd2, 5, 7'h03));
    put(36, e_i(9, 0, 0, 0, 7'h13));
    do_reset();
    run_steps(3);
    #1;
    chk("sb_b0", {24'd0, mem[32'h100]}, 32'h01);
    chk("sb_b1", {24'd0, mem[32'h101]}, 32'h00);
    run_steps(1);
    #1;
    chk("sh_b1", {24'd0, mem[32'h101]}, 32'h7F);
    chk("sh_b2", {24'd0, mem[32'h102]}, 32'h00);
    run_steps(6);
    final_cmp("ls");
    chk("mem100", {mem[32'h103], mem[32'h102], mem[32'h101],
                   mem[32'h100]}, 32'h80FF_7F01);
    chk("lb", dut.r_regs[2], 32'h0000_0001);
    chk("lbu", dut.r_regs[3], 32'h0000_00FF);
    chk("lh", dut.r_regs[4], 32'hFFFF_80FF);
    chk("lw", dut.r_regs[5], 32'h80FF_7F01);
    chk("x0", dut.r_regs[0], 0);

    // random instruction mixes
    for (int p = 0; p < 4; p++) begin
      clear_mem();
      for (int i = 0; i < 48; i++) put(4 * i, rnd_instr());
      for (int i = 32'h200; i < 1024; i += 4) put(i, $urandom);
      do_reset();
      run_steps(48);
      final_cmp($sformatf("rnd%0d", p));
    end

    // reset during store phase 100 must abort the store
    clear_mem();
    put(0, e_i(32'h55, 0, 0, 1, 7'h13));
    put(4, e_s(32'h100, 1, 0, 3'd0));
    mem[32'h100] = 8'hAA;
    m_mem[32'h100] = 8'hAA;
    do_reset();
    run_steps(1);
    repeat (2) @(posedge clock);
    #2;
    chk("st_wr_on", bus.write, 1);
    reset = 1'b1;
    #1;
    chk("st_wr_off", bus.write, 0);
    @(posedge clock); #1;
    chk("st_abort", {24'd0, mem[32'h100]}, 32'hAA);
    chk("st_abort_op", bus.opcode_debug, 32'h13);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
